// File: rtl/coin_input_conditioner.sv
// -----------------------------------------------------------------------------
// coin_input_conditioner
//
// Front end for the vending controller's three raw inputs. It takes the
// 50-coin switch, the 100-coin switch and the dispense button. Each input
// goes through a two-flop synchroniser and then a debouncer. The clean
// levels drive A, B and C, which the vending FSM edge-detects directly.
//
// A coin that keeps A or B high for too long is treated as jammed in the
// chute. The sticky jam flag is raised and all three outputs are blanked
// until the next reset.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive synchronised samples needed to accept a
//                    level change (2..65535)
//   JAM_CYCLES       cycles a clean A or B may stay high before a jam is
//                    declared (2..2^20, greater than DEBOUNCE_CYCLES)
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   synchronous reset, active low
//   a_raw  in   raw 50-coin switch (asynchronous, bouncy)
//   b_raw  in   raw 100-coin switch (asynchronous, bouncy)
//   c_raw  in   raw dispense button (asynchronous, bouncy)
//   A      out  clean 50-coin level
//   B      out  clean 100-coin level
//   C      out  clean dispense level
//   jam    out  sticky jam flag
//
// Optional feature macro: COIN_LOCKOUT_EN
//   When defined, a channel may rise only while the other two clean levels
//   are low. Simultaneous rises are resolved with priority A > B > C.
//   A blocked channel waits at terminal count.
//   Falling transitions are never blocked.
// -----------------------------------------------------------------------------
module coin_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int JAM_CYCLES      = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic a_raw,
   input  logic b_raw,
   input  logic c_raw,
   output logic A,
   output logic B,
   output logic C,
   output logic jam
);

   localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_TERM = CW'(DEBOUNCE_CYCLES - 1);
   localparam int              JW       = 21;
   localparam logic [JW-1:0]   JAM_TERM = JW'(JAM_CYCLES - 1);

   // Channel index: 0 = coin-50 (A), 1 = coin-100 (B), 2 = dispense (C)
   logic [2:0]    raw;
   logic [2:0]    s1;
   logic [2:0]    s2;
   logic [2:0]    lvl;
   logic [2:0]    term;
   logic [2:0]    accept;
   logic [CW-1:0] cnt [3];
   logic [JW-1:0] jcnt;

   // Saturating increment for the jam counter.
   function automatic logic [JW-1:0] sat_inc(input logic [JW-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign raw = {c_raw, b_raw, a_raw};

   // ---- stage: two-flop synchroniser ----
   always_ff @(posedge clk) begin
      if (!rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= raw;
         s2 <= s1;
      end
   end

   // A channel is at terminal count when it still disagrees with its clean
   // level after DEBOUNCE_CYCLES-1 earlier disagreeing samples. This means
   // DEBOUNCE_CYCLES consecutive samples accept a change.
   always_comb begin
      term = '0;
      for (int i = 0; i < 3; i++) begin
         term[i] = (s2[i] != lvl[i]) && (cnt[i] == CNT_TERM);
      end
   end

`ifdef COIN_LOCKOUT_EN
   // A rise needs the other two levels low on this edge. Lower-priority
   // channels also lose to any higher-priority rise on the same edge.
   logic win_a;
   logic win_b;
   logic win_c;

   always_comb begin
      win_a  = term[0] & s2[0] & ~lvl[1] & ~lvl[2];
      win_b  = term[1] & s2[1] & ~lvl[0] & ~lvl[2] & ~win_a;
      win_c  = term[2] & s2[2] & ~lvl[0] & ~lvl[1] & ~win_a & ~win_b;
      accept = (term & ~s2) | {win_c, win_b, win_a};
   end
`else
   always_comb begin
      accept = term;
   end
`endif

   // ---- stage: debounce ----
   // A blocked rise (lockout only) leaves the counter parked at terminal
   // count. The channel can then rise on the first edge where it is allowed.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst) begin
            lvl[i] <= 1'b0;
            cnt[i] <= '0;
         end else if (s2[i] == lvl[i]) begin
            cnt[i] <= '0;
         end else if (accept[i]) begin
            lvl[i] <= s2[i];
            cnt[i] <= '0;
         end else if (cnt[i] != CNT_TERM) begin
            cnt[i] <= cnt[i] + 1'b1;
         end
      end
   end

   // ---- stage: jam detection ----
   // Only the coin channels count. A held dispense button is legal.
   always_ff @(posedge clk) begin
      if (!rst) begin
         jcnt <= '0;
         jam  <= 1'b0;
      end else if (lvl[0] | lvl[1]) begin
         if (jcnt == JAM_TERM) begin
            jam <= 1'b1;
         end
         jcnt <= sat_inc(jcnt);
      end else begin
         jcnt <= '0;
      end
   end

   assign A = lvl[0] & ~jam;
   assign B = lvl[1] & ~jam;
   assign C = lvl[2] & ~jam;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_coin_input_conditioner
//
// Self-checking bench for coin_input_conditioner with DEBOUNCE_CYCLES = 4
// and JAM_CYCLES = 16.
//
// Every edge, each scenario drives the raw inputs and pushes the expected
// {A,B,C,jam}. One time unit after the rising edge, it pops that value and
// compares it against the DUT outputs. Expected windows come from the timing
// rules:
//   - a change sampled at edge E0 shows on the output after edge E0+5;
//   - jam rises 16 edges after a coin level goes high.
// Build with +define+COIN_LOCKOUT_EN to check the lockout variant.
// -----------------------------------------------------------------------------
module tb_coin_input_conditioner;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic a_raw = 1'b0;
   logic b_raw = 1'b0;
   logic c_raw = 1'b0;
   logic A;
   logic B;
   logic C;
   logic jam;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [3:0] exp_q[$];

   coin_input_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .JAM_CYCLES     (16)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .a_raw(a_raw),
      .b_raw(b_raw),
      .c_raw(c_raw),
      .A    (A),
      .B    (B),
      .C    (C),
      .jam  (jam)
   );

   always #5 clk = ~clk;

   // Apply one edge's worth of stimulus away from the active edge.
   task automatic drive(input logic a, input logic b, input logic c, input logic r);
      @(negedge clk);
      a_raw = a;
      b_raw = b;
      c_raw = c;
      rst   = r;
   endtask

   task automatic test_reset();
      logic [3:0] e;
      logic [3:0] o;
      logic       hi;
      // Reset held with every switch closed.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 1'b1, 1'b0);
         exp_q.push_back(4'b0000);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         o = {A, B, C, jam};
         tests_run++;
         if (o !== e) begin
            tests_failed++;
            $display("FAIL reset_hold edge %0d: ABCjam=%b expected %b", i, o, e);
         end
      end
      // Release with switches still closed: fresh rise after the 6th edge.
      for (int i = 0; i < 15; i++) begin
         drive(i < 7, i < 7, i < 7, 1'b1);
         hi = (i >= 5) && (i < 12);
`ifdef COIN_LOCKOUT_EN
         exp_q.push_back({hi, 1'b0, 1'b0, 1'b0});
`else
         exp_q.push_back({hi, hi, hi, 1'b0});
`endif
         @(posedge clk); #1;
         e = exp_q.pop_front();
         o = {A, B, C, jam};
         tests_run++;
         if (o !== e) begin
            tests_failed++;
            $display("FAIL reset_release edge %0d: ABCjam=%b expected %b", i, o, e);
         end
      end
   endtask

   task automatic test_reset_mid_debounce();
      logic [3:0] e;
      logic [3:0] o;
      // Three edges into an A press, reset for one edge, then hold.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 1'b0, (i < 3));
         exp_q.push_back(4'b0000);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         o = {A, B, C, jam};
         tests_run++;
         if (o !== e) begin
            tests_failed++;
            $display("FAIL reset_mid edge %0d: ABCjam=%b expected %b", i, o, e);
         end
      end
      for (int i = 0; i < 15; i++) begin
         drive(i < 7, 1'b0, 1'b0, 1'b1);
         exp_q.push_back({((i >= 5) && (i < 12)), 3'b000});
         @(posedge clk); #1;
         e = exp_q.pop_front();
         o = {A, B, C, jam};
         tests_run++;
         if (o !== e) begin
            tests_failed++;
            $display("FAIL reset_mid_after edge %0d: ABCjam=%b expected %b", i, o, e);
         end
      end
   endtask

   task automatic test_clean_press();
      logic [3:0] e;
      logic [3:0] o;
      logic       prev_a;
      int         rises;
      prev_a = 1'b0;
      rises  = 0;
      for (int i = 0; i < 18; i++) begin
         drive(i < 10, 1'b0, 1'b0, 1'b1);
         exp_q.push_back({((i >= 5) && (i < 15)), 3'b000});
         @(posedge clk); #1;
         e = exp_q.pop_front();
         o = {A, B, C, jam};
         if (A && !prev_a) rises++;
         prev_a = A;
         tests_run++;
         if (o !== e) begin
            tests_failed++;
            $display("FAIL clean_press edge %0d: ABCjam=%b expected %b", i, o, e);
         end
      end
      tests_run++;
      if (rises !== 1) begin
         tests_failed++;
         $display("FAIL clean_press_rises: got %0d rising edges, expected 1", rises);
      end
   endtask

   task automatic test_bounce();
      logic [3:0] e;
      logic [3:0] o;
      logic       pat [11];
      pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 19; i++) begin
         drive(1'b0, (i < 11) ? pat[i] : 1'b0, 1'b0, 1'b1);
         exp_q.push_back({1'b0, ((i >= 10) && (i < 16)), 2'b00});
         @(posedge clk); #1;
         e = exp_q.pop_front();
         o = {A, B, C, jam};
         tests_run++;
         if (o !== e) begin
            tests_failed++;
            $display("FAIL bounce edge %0d: ABCjam=%b expected %b", i, o, e);
         end
      end
   endtask

   task automatic test_button();
      logic [3:0] e;
      logic [3:0] o;
      logic       c;
      // Sequence:
      //   1-edge glitch at 0;
      //   3-edge glitch at 6..8;
      //   button held at 17..36, longer than the jam limit.
      for (int i = 0; i < 45; i++) begin
         c = (i == 0) || ((i >= 6) && (i <= 8)) || ((i >= 17) && (i <= 36));
         drive(1'b0, 1'b0, c, 1'b1);
         exp_q.push_back({2'b00, ((i >= 22) && (i < 42)), 1'b0});
         @(posedge clk); #1;
         e = exp_q.pop_front();
         o = {A, B, C, jam};
         tests_run++;
         if (o !== e) begin
            tests_failed++;
            $display("FAIL button edge %0d: ABCjam=%b expected %b", i, o, e);
         end
      end
   endtask

   task automatic test_jam();
      logic [3:0] e;
      logic [3:0] o;
      logic       j;
      // A held for 30 edges; a dispense press during the jam must be blanked.
      for (int i = 0; i < 40; i++) begin
         drive(i < 30, 1'b0, ((i >= 24) && (i < 32)), 1'b1);
         j = (i >= 21);
         exp_q.push_back({((i >= 5) && (i <= 20)), 2'b00, j});
         @(posedge clk); #1;
         e = exp_q.pop_front();
         o = {A, B, C, jam};
         tests_run++;
         if (o !== e) begin
            tests_failed++;
            $display("FAIL jam edge %0d: ABCjam=%b expected %b", i, o, e);
         end
      end
      // Only reset clears the flag.
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'b0, (i != 0));
         exp_q.push_back(4'b0000);
         @(posedge clk); #1;
         e = exp_q.pop_front();
         o = {A, B, C, jam};
         tests_run++;
         if (o !== e) begin
            tests_failed++;
            $display("FAIL jam_clear edge %0d: ABCjam=%b expected %b", i, o, e);
         end
      end
   endtask

   task automatic test_lockout();
      logic [3:0] e;
      logic [3:0] o;
      logic       ea;
      logic       eb;
      for (int i = 0; i < 25; i++) begin
         drive(i < 7, i < 14, 1'b0, 1'b1);
         ea = (i >= 5) && (i < 12);
`ifdef COIN_LOCKOUT_EN
         eb = (i >= 13) && (i < 19);
`else
         eb = (i >= 5) && (i < 19);
`endif
         exp_q.push_back({ea, eb, 2'b00});
         @(posedge clk); #1;
         e = exp_q.pop_front();
         o = {A, B, C, jam};
         tests_run++;
         if (o !== e) begin
            tests_failed++;
            $display("FAIL lockout edge %0d: ABCjam=%b expected %b", i, o, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_reset_mid_debounce();
      test_clean_press();
      test_bounce();
      test_button();
      test_jam();
      test_lockout();
      tests_run++;
      if (exp_q.size() !== 0) begin
         tests_failed++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
